// File: rtl/v6_pulse_gen_if.sv
// Pulse generator signal bundle: trigger/amplitude/baseline in, sample stream and status out.
// Combinational bundle only; no storage, so it adds no latency.
// No backpressure: the sample stream runs at one sample per clock.
interface v6_pulse_gen_if #(
  parameter int SIZE_OUT = 14
);
  logic                trig;
  logic [SIZE_OUT-1:0] amplitude;
  logic [SIZE_OUT-1:0] baseline;
  logic [SIZE_OUT-1:0] output_data;
  logic                busy;
  logic [7:0]          pileup_cnt;

  // Stimulus side: drives pulse requests and levels, observes the stream.
  modport master (
    output trig,
    output amplitude,
    output baseline,
    input  output_data,
    input  busy,
    input  pileup_cnt
  );

  // Generator side.
  modport slave (
    input  trig,
    input  amplitude,
    input  baseline,
    output output_data,
    output busy,
    output pileup_cnt
  );
endinterface

// File: rtl/v6_pulse_gen.sv
// Synthetic detector pulse generator: linear rise of 2^RISE_SHIFT steps, exponential decay, pile-up.
// Latency: trig sampled at edge N gives the first rise increment on output_data at edge N+2.
// No backpressure: triggers arriving during RISE are dropped and counted in pileup_cnt.
// Optional macro V6_PULSE_GEN_NOISE_LFSR_EN adds small LFSR noise to the output sum.
module v6_pulse_gen #(
  parameter int SIZE_OUT    = 14,
  parameter int RISE_SHIFT  = 2,
  parameter int DECAY_SHIFT = 4,
  parameter int NOISE_BITS  = 3
) (
  input  logic          clk,
  input  logic          reset,
  v6_pulse_gen_if.slave pg
);

  // Two guard bits let stacked pulses climb above the output range before clamping.
  localparam int ACC_W = SIZE_OUT + 2;
  // Output sum needs room for baseline + acc plus a sign bit for negative noise.
  localparam int SUM_W = SIZE_OUT + 4;
  localparam int CNT_W = RISE_SHIFT + 1;

  localparam logic [CNT_W-1:0]        RISE_LAST = CNT_W'((1 << RISE_SHIFT) - 1);
  localparam logic [ACC_W-1:0]        ACC_MAX   = '1;
  localparam logic signed [SUM_W-1:0] OUT_MAX   = SUM_W'((1 << SIZE_OUT) - 1);

  // Noise amplitude must fit inside the 16-bit LFSR and leave a usable range.
  if (NOISE_BITS < 1 || NOISE_BITS > 15) begin : g_bad_noise_bits
    $error("NOISE_BITS must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RISE  = 2'd1,
    DECAY = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ACC_W-1:0]        acc;
  logic [ACC_W-1:0]        decay_amt;
  logic [ACC_W:0]          rise_sum;
  logic [ACC_W-1:0]        acc_rise;
  logic [SIZE_OUT-1:0]     step;
  logic [CNT_W-1:0]        rise_cnt;
  logic [7:0]              pileup_cnt;
  logic                    trig_accept;
  logic                    trig_reject;
  logic                    rise_done;
  logic                    decay_done;
  logic signed [SUM_W-1:0] noise;
  logic signed [SUM_W-1:0] out_sum;
  logic [SIZE_OUT-1:0]     out_clamped;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  assign decay_amt  = acc >> DECAY_SHIFT;
  assign decay_done = (decay_amt == '0);
  assign rise_done  = (rise_cnt == RISE_LAST);

  // One extra bit on the adder exposes the carry used for saturation.
  assign rise_sum = {1'b0, acc} + {{(ACC_W + 1 - SIZE_OUT){1'b0}}, step};
  assign acc_rise = rise_sum[ACC_W] ? ACC_MAX : rise_sum[ACC_W-1:0];

  // A trigger starts a new rise from IDLE or on top of a decaying tail;
  // during RISE it is dropped (including the last rise cycle).
  assign trig_accept = pg.trig && ((state == IDLE) || (state == DECAY));
  assign trig_reject = pg.trig && (state == RISE);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: a fixed-length rise, then decay until the per-cycle decrement vanishes.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (trig_accept) begin
          state_nxt = RISE;
        end
      end
      RISE: begin
        if (rise_done) begin
          state_nxt = DECAY;
        end
      end
      DECAY: begin
        if (trig_accept) begin
          state_nxt = RISE;
        end else if (decay_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    pg.busy = 1'b0;
    if (state != IDLE) begin
      pg.busy = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Pulse shape accumulator
  // ---------------------------------------------------------------------------

  // Accumulator, rise step and rise counter; acc is kept on pile-up so pulses stack.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      step     <= '0;
      rise_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          acc <= '0;
          if (trig_accept) begin
            step     <= pg.amplitude >> RISE_SHIFT;
            rise_cnt <= '0;
          end
        end
        RISE: begin
          acc      <= acc_rise;
          rise_cnt <= rise_cnt + CNT_W'(1);
        end
        DECAY: begin
          if (trig_accept) begin
            step     <= pg.amplitude >> RISE_SHIFT;
            rise_cnt <= '0;
          end else if (decay_done) begin
            acc <= '0;
          end else begin
            acc <= acc - decay_amt;
          end
        end
        default: begin
          acc <= '0;
        end
      endcase
    end
  end

  // Saturating count of triggers that arrived while a rise was in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      pileup_cnt <= '0;
    end else if (trig_reject && (pileup_cnt != 8'hFF)) begin
      pileup_cnt <= pileup_cnt + 8'd1;
    end
  end

  assign pg.pileup_cnt = pileup_cnt;

  // ---------------------------------------------------------------------------
  // Noise source
  // ---------------------------------------------------------------------------
`ifdef V6_PULSE_GEN_NOISE_LFSR_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  // Maximal-length taps 16,14,13,11 give a 65535-cycle repeat period.
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Free-running LFSR, one shift per clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end

  // Centre the low LFSR bits around zero: range -2^(NOISE_BITS-1) .. 2^(NOISE_BITS-1)-1.
  assign noise = $signed({{(SUM_W - NOISE_BITS){1'b0}}, lfsr[NOISE_BITS-1:0]})
               - $signed(SUM_W'(1 << (NOISE_BITS - 1)));
`else
  assign noise = '0;
`endif

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------

  // Baseline plus pulse plus noise, clamped into the unsigned output range.
  always_comb begin
    out_sum = $signed({{(SUM_W - SIZE_OUT){1'b0}}, pg.baseline})
            + $signed({{(SUM_W - ACC_W){1'b0}}, acc})
            + noise;
    out_clamped = out_sum[SIZE_OUT-1:0];
    if (out_sum < 0) begin
      out_clamped = '0;
    end else if (out_sum > OUT_MAX) begin
      out_clamped = OUT_MAX[SIZE_OUT-1:0];
    end
  end

  // Registered sample stream, one cycle behind acc.
  always_ff @(posedge clk) begin
    if (reset) begin
      pg.output_data <= '0;
    end else begin
      pg.output_data <= out_clamped;
    end
  end

endmodule

// File: doc/v6_pulse_gen.md
V6_PULSE_GEN -- requirements
Module: v6_pulse_gen

Interface
REQ-001 SHALL have parameter SIZE_OUT, default 14, sample width (matches shaping-filter input width).
REQ-002 SHALL have parameter RISE_SHIFT, default 2, rise length = 2^RISE_SHIFT cycles.
REQ-003 SHALL have parameter DECAY_SHIFT, default 4, decay per cycle acc>>DECAY_SHIFT.
REQ-004 SHALL have parameter NOISE_BITS, default 3, noise amplitude width (used only with NOISE_LFSR_EN).
REQ-005 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port trig  input  1  pulse request, sampled each edge.
REQ-008 SHALL have port amplitude  input  SIZE_OUT  unsigned pulse height, latched at accepted trig.
REQ-009 SHALL have port baseline  input  SIZE_OUT  unsigned DC offset, sampled every cycle.
REQ-010 SHALL have port output_data  output  SIZE_OUT  registered unsigned sample stream, one sample per clk.
REQ-011 SHALL have port busy  output  1  high when state != IDLE.
REQ-012 SHALL have port pileup_cnt  output  8  saturating count of rejected trigs.

Function
REQ-013 SHALL keep internal unsigned accumulator acc of SIZE_OUT+2 bits and FSM states IDLE, RISE, DECAY.
REQ-014 SHALL accept trig high in IDLE or DECAY: next state RISE, step <= amplitude>>RISE_SHIFT, rise_cnt <= 0; acc retained (pile-up adds on top).
REQ-015 SHALL, in RISE, do acc <= acc + step each cycle (saturating at acc max), rise_cnt++, exactly 2^RISE_SHIFT adds, then DECAY.
REQ-016 SHALL ignore trig in RISE and increment pileup_cnt, saturating at 255.
REQ-017 SHALL, in DECAY without accepted trig, do acc <= acc - (acc>>DECAY_SHIFT); when acc>>DECAY_SHIFT == 0, acc <= 0 and next state IDLE.
REQ-018 SHALL hold acc at 0 in IDLE.
REQ-019 SHALL register output_data <= min(baseline + acc (+noise), 2^SIZE_OUT-1), clamped below at 0; one cycle behind acc.
REQ-020 SHALL give latency: trig sampled at edge N -> first rise increment on output_data at edge N+2.
REQ-021 SHALL treat trig on the final RISE cycle as rejected (REQ-016).
REQ-022 SHALL treat amplitude < 2^RISE_SHIFT as step 0: FSM runs full RISE/DECAY, output stays baseline.

Reset
REQ-023 SHALL, on reset high at an edge, set state IDLE, acc, step, rise_cnt, pileup_cnt, output_data, busy to 0, LFSR to 16'hACE1.
REQ-024 SHALL give reset priority over trig at the same edge; trig ignored, pileup_cnt not incremented.
REQ-025 SHALL abort a pulse on reset mid-RISE/DECAY; output_data 0 on the following edge, busy 0.

Configuration
REQ-026 SHALL, with macro V6_PULSE_GEN_NOISE_LFSR_EN defined, include a 16-bit Fibonacci LFSR (taps 16,14,13,11) advancing every cycle, adding (lfsr[NOISE_BITS-1:0] - 2^(NOISE_BITS-1)) to the output sum before clamping.
REQ-027 SHALL, without V6_PULSE_GEN_NOISE_LFSR_EN, contain no LFSR; output_data exactly per REQ-019.

Verification (macro undefined unless stated; SIZE_OUT=14, RISE_SHIFT=2, DECAY_SHIFT=4)
REQ-028 SHALL cover single pulse: baseline 0, amplitude 400, trig one cycle at edge N -> output_data 100,200,300,400 at edges N+2..N+5, then 375,352, busy low after decay to 0.
REQ-029 SHALL cover pile-up: second trig (amplitude 400) during DECAY at acc 375 -> output rises by 100/cycle from 375 to 775.
REQ-030 SHALL cover rejection: trig held high 4 cycles from IDLE -> one pulse, pileup_cnt = 3; 300 rejected trigs -> pileup_cnt = 255.
REQ-031 SHALL cover saturation: baseline 16000, amplitude 1000 -> output_data clamps at 16383, never wraps.
REQ-032 SHALL cover reset mid-DECAY -> output_data 0, busy 0 next edge; trig with reset ignored.
REQ-033 SHALL cover macro defined, amplitude 0, baseline 100 -> output_data within 96..103, sequence repeating after 65535 cycles.
